wb_mem_arbiter_2m: RTL
======================

Name: wb_mem_arbiter_2m

Overview:
- Two-master Wishbone (pipelined) arbiter that shares one memory port between requesters, e.g. instruction fetch (m0) and load/store unit (m1) onto one port of the dual-port RAM.
- Grants the bus per Wishbone cycle: the grant is held for as long as the granted master keeps cyc high.
- Round-robin priority between masters, with a registered grant.
- Sits between the core bus masters and the memory slave port; it does not modify data, select or address.

Parameters:
- ADDR_WIDTH, 32, address bus width passed through.
- DATA_WIDTH, 32, data bus width.
- SEL_WIDTH, 4, byte-select width (DATA_WIDTH/8).
- TIMEOUT_CYCLES, 16, watchdog limit, used only with the optional feature; legal range 2..255.

Ports:
- wb_clk_i  in  1  single clock for all logic
- wb_rst_i  in  1  asynchronous, active-high reset
- m0_wb_cyc_i / m0_wb_stb_i / m0_wb_we_i  in  1 each  master 0 cycle, strobe, write enable
- m0_wb_adr_i  in  ADDR_WIDTH  master 0 address
- m0_wb_dat_i  in  DATA_WIDTH  master 0 write data
- m0_wb_sel_i  in  SEL_WIDTH  master 0 byte selects
- m0_wb_dat_o  out  DATA_WIDTH  read data to master 0
- m0_wb_ack_o / m0_wb_err_o / m0_wb_stall_o  out  1 each  master 0 ack, error, stall
- m1_wb_*  same set as m0, for master 1
- s_wb_cyc_o / s_wb_stb_o / s_wb_we_o  out  1 each  slave cycle, strobe, write enable
- s_wb_adr_o  out  ADDR_WIDTH  slave address
- s_wb_dat_o  out  DATA_WIDTH  slave write data
- s_wb_sel_o  out  SEL_WIDTH  slave byte selects
- s_wb_dat_i  in  DATA_WIDTH  slave read data
- s_wb_ack_i / s_wb_err_i / s_wb_stall_i  in  1 each  slave ack, error, stall
- grant_o  out  2  one-hot current grant ({m1,m0}); 2'b00 when idle

Behaviour:
- State machine: IDLE, GNT0, GNT1. Registered `prio` bit selects the preferred master on a tie; reset value 0 (m0 preferred).
- IDLE transitions:
  - only m0 cyc high -> GNT0
  - only m1 cyc high -> GNT1
  - both high -> GNT(prio)
  - neither -> stay IDLE
- Entering GNTx sets prio to the other master.
- GNTx: stay while mx_wb_cyc_i=1. When mx_wb_cyc_i=0, go to IDLE. Exactly one IDLE cycle separates grants, so there is no same-cycle handover.
- Latency: grant is registered. A master's first strobe reaches the slave one cycle after its cyc rises, provided the bus is free.
- Slave side:
  - In GNTx, s_wb_cyc_o, stb, we, adr, dat and sel are combinational copies of master x's signals.
  - In IDLE, s_wb_cyc_o=0 and s_wb_stb_o=0; the other slave outputs are don't-care and are driven as 0.
- Granted master: mx_wb_stall_o=s_wb_stall_i, mx_wb_ack_o=s_wb_ack_i, mx_wb_err_o=s_wb_err_i, mx_wb_dat_o=s_wb_dat_i.
- Non-granted master, or any master while IDLE: stall_o=1, ack_o=0, err_o=0, dat_o=0.
- A slave ack/err arriving while IDLE is discarded. This covers a master dropping cyc with an ack outstanding.
- Reset, at any time including mid-cycle: state=IDLE, prio=0, grant_o=0, s_wb_cyc_o=0, s_wb_stb_o=0, all master ack/err=0, all master stall=1. Outputs reach these values asynchronously.
- Masters that hold cyc indefinitely starve the other master; fairness is per Wishbone cycle only.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro: an 8-bit watchdog counter.
  - Cleared in IDLE and on any cycle with s_wb_ack_i or s_wb_err_i.
  - Otherwise increments each GNTx cycle.
  - When the count equals TIMEOUT_CYCLES-1 and there is no ack or err:
    - assert mx_wb_err_o=1 for exactly that one cycle to the granted master;
    - force state to IDLE next cycle, even if cyc is still high;
    - the master must re-request by keeping cyc high, and arbitration resumes normally from IDLE.
  - Sticky status output timeout_o (1 bit): set on a watchdog fire, cleared only by reset.
- Without the macro: no counter, no timeout_o port, and err is purely pass-through.

Test Plan:
- Single master read: m0 cyc+stb at cycle 0, adr=0x40; slave acks at cycle 2 with dat=0xDEADBEEF -> grant_o=01 from cycle 1, s_wb_stb_o=1 at cycle 1, m0_wb_ack_o=1 with m0_wb_dat_o=0xDEADBEEF at cycle 2; m1 stall=1 throughout.
- Simultaneous requests from reset: m0 and m1 raise cyc in the same cycle -> m0 granted first. m0 drops cyc after one ack -> one IDLE cycle, then grant_o=10. Repeat the simultaneous request -> m0 granted again (prio alternated).
- Write pass-through: m1 granted, we=1, sel=4'b0010, dat=0x0000AB00 -> slave sees identical we/sel/dat/adr; m0 sees stall=1 and ack=0.
- Stall propagation: the slave holds stall=1 for 3 cycles during m0 grant -> m0_wb_stall_o=1 for the same 3 cycles; m0 stb is held and is accepted on the first stall=0 cycle.
- Reset mid-cycle: assert wb_rst_i while in GNT1 with stb high -> s_wb_cyc_o=0 and grant_o=00 immediately (asynchronously). After release, m0 wins a tie.
- Timeout (macro defined, TIMEOUT_CYCLES=4): m0 granted, slave never acks -> m0_wb_err_o=1 on the 4th grant cycle, IDLE the next cycle, timeout_o=1 and it stays 1 until reset.

Source files
------------

// File: rtl/wb_mem_arbiter_2m_if.sv
// Pipelined Wishbone bundle for one master/slave link of wb_mem_arbiter_2m.
// dat_w carries write data toward the slave and dat_r carries read data back.
interface wb_mem_arbiter_2m_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int SEL_WIDTH  = 4
);
   logic                  cyc;
   logic                  stb;
   logic                  we;
   logic [ADDR_WIDTH-1:0] adr;
   logic [DATA_WIDTH-1:0] dat_w;
   logic [SEL_WIDTH-1:0]  sel;
   logic [DATA_WIDTH-1:0] dat_r;
   logic                  ack;
   logic                  err;
   logic                  stall;

   modport master (
      output cyc, stb, we, adr, dat_w, sel,
      input  dat_r, ack, err, stall
   );

   modport slave (
      input  cyc, stb, we, adr, dat_w, sel,
      output dat_r, ack, err, stall
   );
endinterface

// File: rtl/wb_mem_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter onto one memory port, granting per bus cycle.
// Optional watchdog (timeout_o, forced release) is enabled with `define WB_ARB_TIMEOUT_EN.
module wb_mem_arbiter_2m #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int SEL_WIDTH      = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_i,
   wb_mem_arbiter_2m_if.slave         m0_wb,
   wb_mem_arbiter_2m_if.slave         m1_wb,
   wb_mem_arbiter_2m_if.master        s_wb,
   output logic [1:0]                 grant_o
`ifdef WB_ARB_TIMEOUT_EN
   ,
   output logic                       timeout_o
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GNT0 = 2'd1,
      ST_GNT1 = 2'd2
   } state_t;

   state_t     r_state;
   logic       r_prio;
   logic [1:0] r_grant;
   logic       w_fire;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("wb_mem_arbiter_2m: TIMEOUT_CYCLES must be within 2..255");
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam logic [7:0] LP_WDT_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] r_wdt;
   logic       r_timeout;

   // Fires on the last permitted silent grant cycle; the err goes out in that same cycle.
   assign w_fire = (r_state != ST_IDLE) && !s_wb.ack && !s_wb.err && (r_wdt == LP_WDT_LAST);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_wdt     <= 8'd0;
         r_timeout <= 1'b0;
      end else begin
         if (r_state == ST_IDLE || s_wb.ack || s_wb.err || w_fire)
            r_wdt <= 8'd0;
         else
            r_wdt <= r_wdt + 8'd1;
         if (w_fire)
            r_timeout <= 1'b1;
      end
   end

   assign timeout_o = r_timeout;
`else
   assign w_fire = 1'b0;
`endif

   // Grant is registered; every handover passes through one IDLE cycle.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state <= ST_IDLE;
         r_prio  <= 1'b0;
         r_grant <= 2'b00;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (m0_wb.cyc && (!m1_wb.cyc || !r_prio)) begin
                  r_state <= ST_GNT0;
                  r_grant <= 2'b01;
                  r_prio  <= 1'b1;
               end else if (m1_wb.cyc) begin
                  r_state <= ST_GNT1;
                  r_grant <= 2'b10;
                  r_prio  <= 1'b0;
               end
            end
            ST_GNT0: begin
               if (!m0_wb.cyc || w_fire) begin
                  r_state <= ST_IDLE;
                  r_grant <= 2'b00;
               end
            end
            ST_GNT1: begin
               if (!m1_wb.cyc || w_fire) begin
                  r_state <= ST_IDLE;
                  r_grant <= 2'b00;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_grant <= 2'b00;
            end
         endcase
      end
   end

   assign grant_o = r_grant;

   always_comb begin
      s_wb.cyc   = 1'b0;
      s_wb.stb   = 1'b0;
      s_wb.we    = 1'b0;
      s_wb.adr   = '0;
      s_wb.dat_w = '0;
      s_wb.sel   = '0;
      case (r_grant)
         2'b01: begin
            s_wb.cyc   = m0_wb.cyc;
            s_wb.stb   = m0_wb.stb;
            s_wb.we    = m0_wb.we;
            s_wb.adr   = m0_wb.adr;
            s_wb.dat_w = m0_wb.dat_w;
            s_wb.sel   = m0_wb.sel;
         end
         2'b10: begin
            s_wb.cyc   = m1_wb.cyc;
            s_wb.stb   = m1_wb.stb;
            s_wb.we    = m1_wb.we;
            s_wb.adr   = m1_wb.adr;
            s_wb.dat_w = m1_wb.dat_w;
            s_wb.sel   = m1_wb.sel;
         end
         default: ;
      endcase
   end

   // Responses arriving while IDLE reach neither master and are dropped.
   assign m0_wb.dat_r = r_grant[0] ? s_wb.dat_r : '0;
   assign m0_wb.ack   = r_grant[0] & s_wb.ack;
   assign m0_wb.err   = r_grant[0] & (s_wb.err | w_fire);
   assign m0_wb.stall = ~r_grant[0] | s_wb.stall;

   assign m1_wb.dat_r = r_grant[1] ? s_wb.dat_r : '0;
   assign m1_wb.ack   = r_grant[1] & s_wb.ack;
   assign m1_wb.err   = r_grant[1] & (s_wb.err | w_fire);
   assign m1_wb.stall = ~r_grant[1] | s_wb.stall;

endmodule
